// File: rtl/bus_timer.sv
// Memory-mapped prescaled timer: COUNT, COMPARE, sticky match flag, level irq.
// Sits on the CPU external data bus next to the MEM stage.
module bus_timer #(
   parameter int PRE_W = 16,
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] addr,
   input  logic        cs,
   input  logic        wr_rd,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        irq
);

   localparam logic [1:0] REG_CTRL = 2'd0;
   localparam logic [1:0] REG_PRE  = 2'd1;
   localparam logic [1:0] REG_CNT  = 2'd2;
   localparam logic [1:0] REG_CMP  = 2'd3;

   logic             en;
   logic             ar;
   logic             ie;
   logic             mf;
   logic [PRE_W-1:0] prescale;
   logic [PRE_W-1:0] pre_cnt;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] compare;

   logic       wr;
   logic       rd;
   logic [1:0] sel;
   logic       tick;
   logic       match;

   assign sel   = addr[3:2];
   assign wr    = cs & wr_rd;
   assign rd    = cs & ~wr_rd;
   assign tick  = en & (pre_cnt == prescale);
   assign match = tick & (count == compare);
   assign irq   = mf & ie;

   always_ff @(posedge clk) begin
      if (!rst) begin
         en       <= 1'b0;
         ar       <= 1'b0;
         ie       <= 1'b0;
         mf       <= 1'b0;
         prescale <= '0;
         pre_cnt  <= '0;
         count    <= '0;
         compare  <= '1;
      end else begin
         if (wr && sel == REG_CTRL) begin
            en <= data_in[0];
            ar <= data_in[1];
            ie <= data_in[2];
         end

         // A match in the same cycle beats a software clear
         if (match)
            mf <= 1'b1;
         else if (wr && sel == REG_CTRL && data_in[8])
            mf <= 1'b0;

         if (wr && sel == REG_PRE)
            prescale <= data_in[PRE_W-1:0];

         if (wr && sel == REG_PRE)
            pre_cnt <= '0;
         else if (tick)
            pre_cnt <= '0;
         else if (en)
            pre_cnt <= pre_cnt + PRE_W'(1);

         // Software write to COUNT overrides the tick update
         if (wr && sel == REG_CNT)
            count <= data_in[CNT_W-1:0];
         else if (tick)
            count <= (match && ar) ? '0 : count + CNT_W'(1);

         if (wr && sel == REG_CMP)
            compare <= data_in[CNT_W-1:0];
      end
   end

   always_comb begin
      data_out = '0;
      if (rd) begin
         unique case (sel)
            REG_CTRL: data_out = {23'd0, mf, 5'd0, ie, ar, en};
            REG_PRE:  data_out = 32'(prescale);
            REG_CNT:  data_out = 32'(count);
            REG_CMP:  data_out = 32'(compare);
            default:  data_out = '0;
         endcase
      end
   end

endmodule
